// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/branch controller: memory commands,
// opcodes, branch condition codes and the controller state enum.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_e;

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_HALT   = 2'b11
    } state_e;

    // Major opcodes in ir[15:13]
    localparam logic [2:0] OP_BCOND = 3'b001;
    localparam logic [2:0] OP_BRL   = 3'b010;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Register/link branch sub-ops in ir[12:11]
    localparam logic [1:0] BR_BX  = 2'b00;
    localparam logic [1:0] BR_BLX = 2'b10;
    localparam logic [1:0] BR_BL  = 2'b11;

    // Conditional branch codes in ir[10:8]
    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    // True for BL/BLX: instructions that write the link register
    function automatic logic is_link(input logic [DATA_W-1:0] insn);
        return (insn[15:13] == OP_BRL) &&
               ((insn[12:11] == BR_BL) || (insn[12:11] == BR_BLX));
    endfunction

endpackage

// File: rtl/branch_fetch_ctrl_if.sv
// Instruction memory read bus between the fetch controller and memory.
interface branch_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 9
) ();

    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_cmd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/branch_cond.sv
// Evaluates a conditional-branch cond code against the datapath flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic       taken
);

    // Condition decode; unlisted codes are never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_B:   taken = 1'b1;
            COND_BEQ: taken = Z;
            COND_BNE: taken = !Z;
            COND_BLT: taken = (N != V);
            COND_BLE: taken = (N != V) || Z;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_fetch_ctrl.sv
// Fetch/decode controller: fetches instructions, resolves branches and
// links in DECODE, hands everything else to the execute FSM, and halts.
module branch_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned LINK_REG = 7
) (
    input  logic                clk,
    input  logic                reset,
    branch_fetch_ctrl_if.master mem,
    input  logic                N,
    input  logic                V,
    input  logic                Z,
    output logic [2:0]          rd_num,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [DATA_W-1:0]   ir,
    output logic                ir_valid,
    input  logic                exec_done,
    output logic                link_we,
    output logic [2:0]          link_num,
    output logic [DATA_W-1:0]   link_data,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    mem_cmd_e            mem_cmd_q, mem_cmd_d;
    logic                ir_valid_q, ir_valid_d;
    logic                link_we_q, link_we_d;
    logic [DATA_W-1:0]   link_data_q, link_data_d;
    logic                halted_q, halted_d;

    logic                taken;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   pc_rel;
    logic [DATA_W-1:0]   offset;

    // Only the low ADDR_W bits of a register target form the new PC
    wire unused_ok = &{1'b0, rd_data};

    assign pc_inc = pc_q + ADDR_W'(1);
    assign offset = {{8{ir_q[7]}}, ir_q[7:0]};
    assign pc_rel = pc_q + offset[ADDR_W-1:0];

    branch_cond u_branch_cond (
        .cond  (ir_q[10:8]),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .taken (taken)
    );

    // Next state, next PC/IR and next registered outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;

        case (state_q)
            S_FETCH: begin
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_inc;
                    state_d = S_DECODE;
                    // Link port is armed one cycle early so it is a clean
                    // register output for exactly the DECODE cycle
                    if (is_link(mem.mem_rdata)) begin
                        link_we_d   = 1'b1;
                        link_data_d = DATA_W'(pc_inc);
                    end
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (ir_q[15:13])
                    OP_BCOND: begin
                        if (taken) begin
                            pc_d = pc_rel;
                        end
                    end
                    OP_BRL: begin
                        case (ir_q[12:11])
                            BR_BL:         pc_d = pc_rel;
                            BR_BX, BR_BLX: pc_d = rd_data[ADDR_W-1:0];
                            default:       pc_d = pc_q;
                        endcase
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        mem_cmd_d  = (state_d == S_FETCH) ? MEM_READ : MEM_NONE;
        ir_valid_d = (state_d == S_EXEC);
        halted_d   = (state_d == S_HALT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= ADDR_W'(RESET_PC);
            ir_q        <= '0;
            mem_cmd_q   <= MEM_READ;
            ir_valid_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mem_cmd_q   <= mem_cmd_d;
            ir_valid_q  <= ir_valid_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            halted_q    <= halted_d;
        end
    end

    assign mem.mem_cmd  = mem_cmd_q;
    assign mem.mem_addr = pc_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign rd_num       = ir_q[7:5];
    assign ir_valid     = ir_valid_q;
    assign link_we      = link_we_q;
    assign link_num     = 3'(LINK_REG);
    assign link_data    = link_data_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Directed bench for branch_fetch_ctrl: a 9-bit-PC instance for fetch,
// branch, link, execute and halt, and a 4-bit-PC instance for wrap/reset.
module tb_branch_fetch_ctrl;
    import cpu_pkg::*;

    logic clk;
    int   tests_run;
    int   tests_failed;

    // Instance A: ADDR_W=9, RESET_PC=0
    logic        a_reset;
    logic        a_n, a_v, a_z;
    logic [2:0]  a_rd_num;
    logic [15:0] a_rd_data;
    logic [15:0] a_ir;
    logic        a_ir_valid;
    logic        a_exec_done;
    logic        a_link_we;
    logic [2:0]  a_link_num;
    logic [15:0] a_link_data;
    logic [8:0]  a_pc;
    logic        a_halted;

    branch_fetch_ctrl_if #(.ADDR_W(9)) a_if ();

    branch_fetch_ctrl #(.ADDR_W(9), .RESET_PC(0), .LINK_REG(7)) u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .mem       (a_if.master),
        .N         (a_n),
        .V         (a_v),
        .Z         (a_z),
        .rd_num    (a_rd_num),
        .rd_data   (a_rd_data),
        .ir        (a_ir),
        .ir_valid  (a_ir_valid),
        .exec_done (a_exec_done),
        .link_we   (a_link_we),
        .link_num  (a_link_num),
        .link_data (a_link_data),
        .pc        (a_pc),
        .halted    (a_halted)
    );

    // Instance B: ADDR_W=4, RESET_PC=3
    logic        b_reset;
    logic [2:0]  b_rd_num;
    logic [15:0] b_ir;
    logic        b_ir_valid;
    logic        b_link_we;
    logic [2:0]  b_link_num;
    logic [15:0] b_link_data;
    logic [3:0]  b_pc;
    logic        b_halted;

    branch_fetch_ctrl_if #(.ADDR_W(4)) b_if ();

    branch_fetch_ctrl #(.ADDR_W(4), .RESET_PC(3), .LINK_REG(7)) u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .mem       (b_if.master),
        .N         (1'b0),
        .V         (1'b0),
        .Z         (1'b0),
        .rd_num    (b_rd_num),
        .rd_data   (16'h0000),
        .ir        (b_ir),
        .ir_valid  (b_ir_valid),
        .exec_done (1'b0),
        .link_we   (b_link_we),
        .link_num  (b_link_num),
        .link_data (b_link_data),
        .pc        (b_pc),
        .halted    (b_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction to A for a single ready cycle; lands in DECODE
    task automatic a_fetch(input logic [15:0] insn);
        a_if.mem_ready = 1'b1;
        a_if.mem_rdata = insn;
        tick();
        a_if.mem_ready = 1'b0;
    endtask

    task automatic b_fetch(input logic [15:0] insn);
        b_if.mem_ready = 1'b1;
        b_if.mem_rdata = insn;
        tick();
        b_if.mem_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        a_reset = 1'b1; a_n = 1'b0; a_v = 1'b0; a_z = 1'b0;
        a_rd_data = 16'h0000; a_exec_done = 1'b0;
        a_if.mem_ready = 1'b0; a_if.mem_rdata = 16'h0000;
        b_reset = 1'b1;
        b_if.mem_ready = 1'b0; b_if.mem_rdata = 16'h0000;

        tick();
        tick();
        chk("a_rst_pc",       32'(a_pc), 32'h0);
        chk("a_rst_ir",       32'(a_ir), 32'h0);
        chk("a_rst_cmd",      32'(a_if.mem_cmd), 32'(MEM_READ));
        chk("a_rst_addr",     32'(a_if.mem_addr), 32'h0);
        chk("a_rst_ir_valid", 32'(a_ir_valid), 32'h0);
        chk("a_rst_link_we",  32'(a_link_we), 32'h0);
        chk("a_rst_halted",   32'(a_halted), 32'h0);

        // Fetch stall: request held stable, ir untouched
        a_reset = 1'b0;
        a_if.mem_rdata = 16'h0123;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_cmd",  32'(a_if.mem_cmd), 32'(MEM_READ));
            chk("stall_addr", 32'(a_if.mem_addr), 32'h0);
            chk("stall_ir",   32'(a_ir), 32'h0);
        end

        // ADD (opcode 000) at 0: DECODE then EXEC until exec_done
        a_fetch(16'h0123);
        chk("add_ir",        32'(a_ir), 32'h0123);
        chk("add_pc",        32'(a_pc), 32'h1);
        chk("add_dec_cmd",   32'(a_if.mem_cmd), 32'(MEM_NONE));
        chk("add_dec_valid", 32'(a_ir_valid), 32'h0);
        tick();
        chk("add_exec_valid", 32'(a_ir_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("exec_valid_hold", 32'(a_ir_valid), 32'h1);
            chk("exec_cmd_none",   32'(a_if.mem_cmd), 32'(MEM_NONE));
            chk("exec_pc_hold",    32'(a_pc), 32'h1);
        end
        a_exec_done = 1'b1;
        tick();
        chk("done_valid", 32'(a_ir_valid), 32'h0);
        chk("done_cmd",   32'(a_if.mem_cmd), 32'(MEM_READ));
        chk("done_addr",  32'(a_if.mem_addr), 32'h1);
        // exec_done in FETCH changes nothing
        tick();
        chk("done_ignored_cmd",   32'(a_if.mem_cmd), 32'(MEM_READ));
        chk("done_ignored_valid", 32'(a_ir_valid), 32'h0);
        a_exec_done = 1'b0;

        // B +3 at 1 -> 2+3 = 5
        a_fetch(16'h2003);
        tick();
        chk("b_always_pc", 32'(a_pc), 32'h5);
        chk("b_cmd_read",  32'(a_if.mem_cmd), 32'(MEM_READ));

        // BEQ -2 at 5, Z=1 -> 4
        a_z = 1'b1;
        a_fetch(16'h21FE);
        tick();
        chk("beq_taken_pc", 32'(a_pc), 32'h4);
        // cond 111 at 4 never taken -> 5
        a_fetch(16'h2700);
        tick();
        chk("cond7_pc", 32'(a_pc), 32'h5);
        // BEQ -2 at 5, Z=0 -> 6
        a_z = 1'b0;
        a_fetch(16'h21FE);
        tick();
        chk("beq_nt_pc", 32'(a_pc), 32'h6);
        // BNE +3 at 6, Z=0 -> 7+3 = 10
        a_fetch(16'h2203);
        chk("bne_dec_link_we", 32'(a_link_we), 32'h0);
        tick();
        chk("bne_pc", 32'(a_pc), 32'hA);

        // BL +3 at 10 -> link 11, pc 14
        a_fetch(16'h5803);
        chk("bl_link_we",   32'(a_link_we), 32'h1);
        chk("bl_link_num",  32'(a_link_num), 32'h7);
        chk("bl_link_data", 32'(a_link_data), 32'hB);
        tick();
        chk("bl_pc",         32'(a_pc), 32'hE);
        chk("bl_link_we_off", 32'(a_link_we), 32'h0);

        // BX r3 at 14, r3 = 0x0020
        a_fetch(16'h4060);
        chk("bx_rd_num",  32'(a_rd_num), 32'h3);
        chk("bx_link_we", 32'(a_link_we), 32'h0);
        a_rd_data = 16'h0020;
        tick();
        chk("bx_pc", 32'(a_pc), 32'h020);

        // BLX r2 at 0x20, r2 = 0x01F5 -> link 0x21
        a_fetch(16'h5040);
        chk("blx_rd_num",    32'(a_rd_num), 32'h2);
        chk("blx_link_we",   32'(a_link_we), 32'h1);
        chk("blx_link_data", 32'(a_link_data), 32'h21);
        a_rd_data = 16'h01F5;
        tick();
        chk("blx_pc", 32'(a_pc), 32'h1F5);

        // BLE +5 at 0x1F5, flags clear -> not taken, 0x1F6
        a_fetch(16'h2405);
        tick();
        chk("ble_nt_pc", 32'(a_pc), 32'h1F6);
        // BLE -16 at 0x1F6, Z=1 -> 0x1F7-0x10 = 0x1E7
        a_z = 1'b1;
        a_fetch(16'h24F0);
        tick();
        chk("ble_taken_pc", 32'(a_pc), 32'h1E7);
        a_z = 1'b0;
        // BLT +1 at 0x1E7, N=1 V=0 -> 0x1E9
        a_n = 1'b1;
        a_fetch(16'h2301);
        tick();
        chk("blt_taken_pc", 32'(a_pc), 32'h1E9);
        a_n = 1'b0;

        // HALT at 0x1E9
        a_fetch(16'hE000);
        tick();
        chk("halt_halted", 32'(a_halted), 32'h1);
        chk("halt_cmd",    32'(a_if.mem_cmd), 32'(MEM_NONE));
        a_if.mem_ready = 1'b1;
        a_if.mem_rdata = 16'h0123;
        tick();
        tick();
        chk("halt_stays",   32'(a_halted), 32'h1);
        chk("halt_pc_hold", 32'(a_pc), 32'h1EA);
        chk("halt_ir_hold", 32'(a_ir), 32'hE000);
        a_if.mem_ready = 1'b0;
        a_reset = 1'b1;
        tick();
        chk("halt_rst_halted", 32'(a_halted), 32'h0);
        chk("halt_rst_pc",     32'(a_pc), 32'h0);
        chk("halt_rst_cmd",    32'(a_if.mem_cmd), 32'(MEM_READ));
        a_reset = 1'b0;

        // Instance B: wrap and reset during a fetch stall
        tick();
        chk("b_rst_pc", 32'(b_pc), 32'h3);
        b_reset = 1'b0;
        // B +11 at 3 -> 4+11 = 15
        b_fetch(16'h200B);
        tick();
        chk("b_pc15", 32'(b_pc), 32'hF);
        // B +2 at 15: increment wraps to 0, then 0+2 = 2
        b_fetch(16'h2002);
        chk("b_inc_wrap", 32'(b_pc), 32'h0);
        tick();
        chk("b_branch_wrap", 32'(b_pc), 32'h2);
        chk("b_wrap_addr",   32'(b_if.mem_addr), 32'h2);
        tick();
        chk("b_stall_cmd", 32'(b_if.mem_cmd), 32'(MEM_READ));
        b_reset = 1'b1;
        b_if.mem_ready = 1'b1;
        b_if.mem_rdata = 16'hABCD;
        tick();
        chk("b_mid_rst_pc", 32'(b_pc), 32'h3);
        chk("b_mid_rst_ir", 32'(b_ir), 32'h0);
        b_reset = 1'b0;
        b_if.mem_ready = 1'b0;
        tick();
        chk("b_refetch_cmd",  32'(b_if.mem_cmd), 32'(MEM_READ));
        chk("b_refetch_addr", 32'(b_if.mem_addr), 32'h3);
        chk("b_refetch_ir",   32'(b_ir), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
